serial_comparator_framed: RTL and testbench
===========================================

# serial_comparator_framed

Parametrised framed serial comparator. Two operands arrive as streams of DIGIT_W-bit digits; a per-word FSM tracks the running relation and, one cycle after the last digit, registers a one-hot result with a valid pulse. Bit order (MSB- or LSB-first) and signedness are selected by parameter. Successor to the single-bit serial comparators; used wherever two serial buses are compared word by word.

## Interface

Parameters:
- DIGIT_W, 1 — bits per digit transferred per cycle; ≥1.
- MSB_FIRST, 1 — 1: most significant digit first; 0: least significant digit first.
- SIGNED, 0 — 1: operands are two's complement; the MSB of the most significant digit is the sign bit.

Ports:
- clk  in  1  — single clock; all state changes on posedge.
- rst  in  1  — synchronous, active-high reset.
- vld  in  1  — a, b, last carry a valid digit this cycle.
- last  in  1  — this digit ends the word; qualified by vld.
- a  in  DIGIT_W  — operand A digit.
- b  in  DIGIT_W  — operand B digit.
- res_vld  out  1  — one-cycle pulse: result flags updated.
- a_less_b  out  1  — registered result, held until next res_vld.
- a_eq_b  out  1  — registered result, held until next res_vld.
- a_greater_b  out  1  — registered result, held until next res_vld.

## Operation

- FSM states: ST_IDLE (no word open), ST_EQ, ST_LT, ST_GT.
- ST_IDLE: the next accepted digit is the first digit of a word.
- Digit relation: dlt/dgt come from comparing a and b.
  - Unsigned compare by default.
  - Signed compare only for the sign digit: the first digit when MSB_FIRST=1, the last digit when MSB_FIRST=0, with SIGNED=1.
  - A single-digit word (vld & last in ST_IDLE) is the sign digit in either mode.
- Update rule when vld=1, where "prior" is ST_EQ when the state is ST_IDLE:
  - MSB_FIRST=1: if prior is ST_LT or ST_GT, keep it (sticky). Otherwise go to ST_LT if dlt, ST_GT if dgt, else ST_EQ.
  - MSB_FIRST=0: go to ST_LT if dlt, ST_GT if dgt, else keep prior. Later digits dominate.
- The updated relation is "new".
- vld & last: the result registers load from new; res_vld <= 1; FSM returns to ST_IDLE.
- vld & ~last: FSM <= new.
- vld=0: FSM and result registers hold; res_vld <= 0. Bubbles are allowed anywhere inside a word.
- last without vld is ignored.
- Exactly one result flag is high whenever any flag is high.

## Timing

- Reset values:
  - FSM = ST_IDLE.
  - res_vld = 0, a_less_b = 0, a_eq_b = 0, a_greater_b = 0. All flags are zero until the first result.
- Latency: res_vld and the flags update on the clock edge that samples vld & last. They are visible in the cycle after the last digit.
- Throughput: back-to-back words with no gap are allowed. A digit with vld=1 in the cycle after last is the first digit of the next word.
- Result flags persist across idle cycles and change only together with res_vld=1.
- rst asserted mid-word: the partial word is discarded and no res_vld is produced. rst wins over a simultaneous vld & last.
- Word length is unbounded; there is no digit counter and no overflow condition.

## Structure

- Package serial_cmp_pkg holds:
  - state enum (ST_IDLE, ST_EQ, ST_LT, ST_GT, 2 bits);
  - relation helper enum (REL_EQ, REL_LT, REL_GT).
- Sub-module serial_cmp_digit (combinational):
  - parameter DIGIT_W; inputs a, b, is_signed;
  - outputs dlt, dgt.
  - The top level drives is_signed = SIGNED & sign-digit.
- Top level holds the FSM, next-state logic, and the result and res_vld registers.

## Test plan

- DIGIT_W=1, MSB_FIRST=1, unsigned: a=1010, b=1001 sent MSB first, last on the 4th digit → res_vld for one cycle after it; a_greater_b=1, others 0.
- DIGIT_W=1, MSB_FIRST=0: same values sent LSB first (a: 0,1,0,1; b: 1,0,0,1) → a_greater_b=1, even though the first digit showed a<b.
- DIGIT_W=4, MSB_FIRST=1, SIGNED=1:
  - a=0x80 (−128), b=0x7F → a_less_b=1.
  - Repeat with SIGNED=0 → a_greater_b=1.
- DIGIT_W=4, SIGNED=1, single digit a=0xF, b=0x1 with vld & last in ST_IDLE → a_less_b=1. Then idle 5 cycles → flags held, res_vld=0.
- DIGIT_W=2, MSB_FIRST=1: word a=0x3C, b=0x3C sent with vld bubbles between digits, immediately followed by a second word a=0x01, b=0x02 → two res_vld pulses:
  - first with a_eq_b=1;
  - second with a_less_b=1.
- Reset mid-word:
  - Send 2 of 4 digits, then rst for 1 cycle → no res_vld; flags 0.
  - A fresh word a=5, b=5 (DIGIT_W=4, single digit) → a_eq_b=1.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the framed serial comparator: per-word FSM states and
// the relation of a single digit pair.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EQ   = 2'd1,
    ST_LT   = 2'd2,
    ST_GT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  function automatic rel_t digit_rel(input logic dlt, input logic dgt);
    rel_t r;
    r = REL_EQ;
    if (dlt)      r = REL_LT;
    else if (dgt) r = REL_GT;
    return r;
  endfunction

  function automatic state_t rel_to_state(input rel_t r);
    state_t s;
    case (r)
      REL_LT:  s = ST_LT;
      REL_GT:  s = ST_GT;
      default: s = ST_EQ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// Combinational compare of one digit pair; signed only when the digit
// carries the operand sign bit.
module serial_cmp_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               is_signed,
  output logic               dlt,
  output logic               dgt
);

  logic w_lt_u;
  logic w_gt_u;
  logic w_lt_s;
  logic w_gt_s;

  assign w_lt_u = (a < b);
  assign w_gt_u = (a > b);
  assign w_lt_s = ($signed(a) < $signed(b));
  assign w_gt_s = ($signed(a) > $signed(b));

  assign dlt = is_signed ? w_lt_s : w_lt_u;
  assign dgt = is_signed ? w_gt_s : w_gt_u;

endmodule

// File: rtl/serial_comparator_framed.sv
// Framed serial comparator: folds a word of digits into a running relation
// and registers one-hot result flags with a valid pulse after the last digit.
module serial_comparator_framed
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W   = 1,
  parameter int MSB_FIRST = 1,
  parameter int SIGNED    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               last,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               res_vld,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b
);

  state_t r_state;
  state_t w_state_next;
  state_t w_prior;
  state_t w_new;
  rel_t   w_rel;
  logic   w_first;
  logic   w_sign_digit;
  logic   w_is_signed;
  logic   w_dlt;
  logic   w_dgt;
  logic   r_res_vld;
  logic   r_lt;
  logic   r_eq;
  logic   r_gt;

  // A single-digit word is both first and last, so it is the sign digit in either order.
  assign w_first      = (r_state == ST_IDLE);
  assign w_sign_digit = (MSB_FIRST != 0) ? w_first : last;
  assign w_is_signed  = (SIGNED != 0) && w_sign_digit;

  serial_cmp_digit #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a        (a),
    .b        (b),
    .is_signed(w_is_signed),
    .dlt      (w_dlt),
    .dgt      (w_dgt)
  );

  always_comb begin
    w_prior      = (r_state == ST_IDLE) ? ST_EQ : r_state;
    w_rel        = digit_rel(w_dlt, w_dgt);
    w_new        = w_prior;
    w_state_next = r_state;
    // MSB-first: the first differing digit decides; LSB-first: the latest differing digit decides.
    if (MSB_FIRST != 0) begin
      if (w_prior == ST_EQ) w_new = rel_to_state(w_rel);
    end else if (w_rel != REL_EQ) begin
      w_new = rel_to_state(w_rel);
    end
    if (vld) w_state_next = last ? ST_IDLE : w_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_vld <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
    end else begin
      r_res_vld <= vld && last;
      if (vld && last) begin
        r_lt <= (w_new == ST_LT);
        r_eq <= (w_new == ST_EQ);
        r_gt <= (w_new == ST_GT);
      end
    end
  end

  assign res_vld     = r_res_vld;
  assign a_less_b    = r_lt;
  assign a_eq_b      = r_eq;
  assign a_greater_b = r_gt;

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Scoreboard bench: six comparator configurations share clk/rst; expected
// flags ({lt,eq,gt}) are queued at issue and popped by a monitor on res_vld.
module tb_serial_comparator_framed;

  localparam int N = 6;
  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  typedef struct packed {
    logic [2:0] id;
    logic [2:0] flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] vld_v = '0;
  logic [N-1:0] last_v = '0;
  logic [3:0] a_v [N];
  logic [3:0] b_v [N];
  logic [N-1:0] res_vld_v;
  logic [N-1:0] lt_v;
  logic [N-1:0] eq_v;
  logic [N-1:0] gt_v;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // 0: W1 MSB unsigned, 1: W1 LSB unsigned, 2: W4 MSB signed,
  // 3: W4 MSB unsigned, 4: W2 MSB unsigned, 5: W4 LSB signed
  serial_comparator_framed #(.DIGIT_W(1), .MSB_FIRST(1), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .vld(vld_v[0]), .last(last_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
    .res_vld(res_vld_v[0]), .a_less_b(lt_v[0]), .a_eq_b(eq_v[0]), .a_greater_b(gt_v[0]));
  serial_comparator_framed #(.DIGIT_W(1), .MSB_FIRST(0), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .vld(vld_v[1]), .last(last_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .res_vld(res_vld_v[1]), .a_less_b(lt_v[1]), .a_eq_b(eq_v[1]), .a_greater_b(gt_v[1]));
  serial_comparator_framed #(.DIGIT_W(4), .MSB_FIRST(1), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .vld(vld_v[2]), .last(last_v[2]), .a(a_v[2]), .b(b_v[2]),
    .res_vld(res_vld_v[2]), .a_less_b(lt_v[2]), .a_eq_b(eq_v[2]), .a_greater_b(gt_v[2]));
  serial_comparator_framed #(.DIGIT_W(4), .MSB_FIRST(1), .SIGNED(0)) u3 (
    .clk(clk), .rst(rst), .vld(vld_v[3]), .last(last_v[3]), .a(a_v[3]), .b(b_v[3]),
    .res_vld(res_vld_v[3]), .a_less_b(lt_v[3]), .a_eq_b(eq_v[3]), .a_greater_b(gt_v[3]));
  serial_comparator_framed #(.DIGIT_W(2), .MSB_FIRST(1), .SIGNED(0)) u4 (
    .clk(clk), .rst(rst), .vld(vld_v[4]), .last(last_v[4]), .a(a_v[4][1:0]), .b(b_v[4][1:0]),
    .res_vld(res_vld_v[4]), .a_less_b(lt_v[4]), .a_eq_b(eq_v[4]), .a_greater_b(gt_v[4]));
  serial_comparator_framed #(.DIGIT_W(4), .MSB_FIRST(0), .SIGNED(1)) u5 (
    .clk(clk), .rst(rst), .vld(vld_v[5]), .last(last_v[5]), .a(a_v[5]), .b(b_v[5]),
    .res_vld(res_vld_v[5]), .a_less_b(lt_v[5]), .a_eq_b(eq_v[5]), .a_greater_b(gt_v[5]));

  task automatic send(input int k, input logic [3:0] av, input logic [3:0] bv, input logic lst);
    vld_v[k]  = 1'b1;
    last_v[k] = lst;
    a_v[k]    = av;
    b_v[k]    = bv;
    @(posedge clk);
    #1;
    vld_v[k]  = 1'b0;
    last_v[k] = 1'b0;
  endtask

  task automatic bubble(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_res(input int k, input logic [2:0] flags);
    exp_t e;
    e.id    = 3'(k);
    e.flags = flags;
    exp_q.push_back(e);
  endtask

  // Direct check of held flags with res_vld low, sampled at the negedge.
  task automatic check_held(input int k, input logic [2:0] flags, input string name);
    logic [3:0] got;
    @(negedge clk);
    got = {res_vld_v[k], lt_v[k], eq_v[k], gt_v[k]};
    n_vec++;
    if (got !== {1'b0, flags}) begin
      n_err++;
      $display("FAIL %s inst%0d: got vld/lt/eq/gt=%b, want %b", name, k, got, {1'b0, flags});
    end else begin
      $display("ok   %s inst%0d: vld/lt/eq/gt=%b", name, k, got);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
          if (res_vld_v[k] === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_res inst%0d: got lt/eq/gt=%b, want no res_vld", k,
                       {lt_v[k], eq_v[k], gt_v[k]});
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              if (e.id != 3'(k) || {lt_v[k], eq_v[k], gt_v[k]} !== e.flags) begin
                n_err++;
                $display("FAIL result inst%0d: got lt/eq/gt=%b, want inst%0d %b", k,
                         {lt_v[k], eq_v[k], gt_v[k]}, e.id, e.flags);
              end else begin
                $display("ok   result inst%0d: lt/eq/gt=%b", k, {lt_v[k], eq_v[k], gt_v[k]});
              end
            end
          end
        end
      end
    join_none

    bubble(3);
    rst = 1'b0;
    for (int k = 0; k < N; k++) check_held(k, 3'b000, "reset_state");
    #1;

    // 1-bit MSB-first: 1010 vs 1001
    send(0, 1, 1, 0); send(0, 0, 0, 0); send(0, 1, 0, 0);
    expect_res(0, GT); send(0, 0, 1, 1);
    // 1-bit MSB-first: 0110 vs 0111
    send(0, 0, 0, 0); send(0, 1, 1, 0); send(0, 1, 1, 0);
    expect_res(0, LT); send(0, 0, 1, 1);
    bubble(2);

    // 1-bit LSB-first: a=1010 -> 0,1,0,1 ; b=1001 -> 1,0,0,1
    send(1, 0, 1, 0); send(1, 1, 0, 0); send(1, 0, 0, 0);
    expect_res(1, GT); send(1, 1, 1, 1);
    bubble(2);

    // 4-bit MSB-first signed: 0x80 vs 0x7F
    send(2, 4'h8, 4'h7, 0);
    expect_res(2, LT); send(2, 4'h0, 4'hF, 1);
    // same operands unsigned
    send(3, 4'h8, 4'h7, 0);
    expect_res(3, GT); send(3, 4'h0, 4'hF, 1);
    // 4-bit LSB-first signed: 0x80 vs 0x7F, sign digit last
    send(5, 4'h0, 4'hF, 0);
    expect_res(5, LT); send(5, 4'h8, 4'h7, 1);
    bubble(2);

    // single signed digit -1 vs 1, then hold across idle cycles
    expect_res(2, LT); send(2, 4'hF, 4'h1, 1);
    bubble(5);
    check_held(2, LT, "held_after_idle");
    #1;

    // 2-bit: 0x3C vs 0x3C with bubbles, then 0x01 vs 0x02 back to back
    send(4, 0, 0, 0); bubble(1);
    send(4, 3, 3, 0); bubble(2);
    send(4, 3, 3, 0); bubble(1);
    expect_res(4, EQ); send(4, 0, 0, 1);
    send(4, 0, 0, 0); send(4, 0, 0, 0); send(4, 0, 0, 0);
    expect_res(4, LT); send(4, 1, 2, 1);
    bubble(2);

    // reset mid-word: two of four digits, then rst
    send(2, 4'h1, 4'h2, 0); send(2, 4'h3, 4'h3, 0);
    rst = 1'b1;
    bubble(1);
    rst = 1'b0;
    check_held(2, 3'b000, "mid_word_reset");
    #1;
    // rst coinciding with vld & last yields no result
    rst = 1'b1;
    send(3, 4'h2, 4'h1, 1);
    rst = 1'b0;
    check_held(3, 3'b000, "rst_beats_last");
    #1;
    expect_res(2, EQ); send(2, 4'h5, 4'h5, 1);
    bubble(4);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_results: got %0d results outstanding, want 0", exp_q.size());
    end else begin
      $display("ok   missing_results: none outstanding");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
